// File: rtl/ballot_capture_if.sv
// ballot_capture_if
// Bundles the voting-booth signals between the button panel/officer side and
// the ballot capture stage.
//   btn            raw candidate buttons (bit0 = cand0 .. bit2 = cand2)
//   ballot_issue   presiding-officer ballot button level
//   vswitch        one-hot vote towards the counter
//   en             one-cycle vote strobe
//   ready          ballot lamp, lit while a ballot is open
//   multi_err      one-cycle pulse on a multi-button press
//   timeout        one-cycle pulse when an open ballot expires
//   ballots_issued running count of ballots issued
// modport master: the panel side (drives buttons, observes results)
// modport slave : the capture stage
interface ballot_capture_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       btn;
    logic             ballot_issue;
    logic [2:0]       vswitch;
    logic             en;
    logic             ready;
    logic             multi_err;
    logic             timeout;
    logic [CNT_W-1:0] ballots_issued;

    modport master (
        output btn, ballot_issue,
        input  vswitch, en, ready, multi_err, timeout, ballots_issued
    );

    modport slave (
        input  btn, ballot_issue,
        output vswitch, en, ready, multi_err, timeout, ballots_issued
    );
endinterface

// File: rtl/ballot_capture.sv
// ballot_capture
// Front end of the vote counter: synchronises and debounces the candidate
// buttons, and lets exactly one single-button vote through per ballot issued
// by the presiding officer.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  ballot_capture_if.slave (buttons and ballot_issue in; vswitch, en,
//        ready, multi_err, timeout, ballots_issued out, all registered)
module ballot_capture #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 8
) (
    input logic             clk,
    input logic             rst,
    ballot_capture_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAST, LOCK} state_t;

    state_t state, next_state;

    logic [2:0]       btn_meta, btn_sync;
    logic             bi_meta, bi_sync, bi_prev;
    logic [2:0]       deb, deb_prev;
    logic [DW-1:0]    deb_cnt [3];
    logic [TW-1:0]    tcnt, tcnt_d;
    logic [CNT_W-1:0] ballots, ballots_d;

    logic [2:0] vswitch_q, vswitch_d;
    logic       en_q, en_d;
    logic       ready_q, ready_d;
    logic       multi_q, multi_d;
    logic       to_q, to_d;

    logic bi_rise, press_evt;

    // Two-flop synchronisers for all asynchronous inputs; bi_prev keeps the
    // previous synchronised ballot level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            bi_meta  <= 1'b0;
            bi_sync  <= 1'b0;
            bi_prev  <= 1'b0;
        end else begin
            btn_meta <= bus.btn;
            btn_sync <= btn_meta;
            bi_meta  <= bus.ballot_issue;
            bi_sync  <= bi_meta;
            bi_prev  <= bi_sync;
        end
    end

    // Per-bit debounce: a bit follows its synchronised level only after the
    // two have disagreed for DEBOUNCE consecutive cycles; any agreement
    // (a bounce back) restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 3; i++) begin
                if (btn_sync[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= btn_sync[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign bi_rise   = bi_sync & ~bi_prev;
    // A press only counts when coming from all-released, so a held or
    // partially released combination never fires twice.
    assign press_evt = (deb != 3'b000) && (deb_prev == 3'b000);

    // Next-state and next-output logic; every output is computed here and
    // registered below so the counter sees glitch-free levels.
    always_comb begin
        next_state = state;
        tcnt_d     = tcnt;
        ballots_d  = ballots;
        vswitch_d  = 3'b000;
        en_d       = 1'b0;
        multi_d    = 1'b0;
        to_d       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bi_rise) begin
                    next_state = ARMED;
                    tcnt_d     = '0;
                    ballots_d  = ballots + CNT_W'(1);
                end
            end
            ARMED: begin
                // A valid vote beats a simultaneous expiry.
                if (press_evt && $onehot(deb)) begin
                    next_state = CAST;
                    en_d       = 1'b1;
                    vswitch_d  = deb;
                end else begin
                    if (press_evt) multi_d = 1'b1;
                    if (tcnt == TO_LAST) begin
                        next_state = IDLE;
                        to_d       = 1'b1;
                    end else begin
                        tcnt_d = tcnt + TW'(1);
                    end
                end
            end
            CAST: next_state = LOCK;
            LOCK: begin
                if (deb == 3'b000 && !bi_sync) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        ready_d = (next_state == ARMED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            ballots   <= '0;
            vswitch_q <= 3'b000;
            en_q      <= 1'b0;
            ready_q   <= 1'b0;
            multi_q   <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state     <= next_state;
            tcnt      <= tcnt_d;
            ballots   <= ballots_d;
            vswitch_q <= vswitch_d;
            en_q      <= en_d;
            ready_q   <= ready_d;
            multi_q   <= multi_d;
            to_q      <= to_d;
        end
    end

    assign bus.vswitch        = vswitch_q;
    assign bus.en             = en_q;
    assign bus.ready          = ready_q;
    assign bus.multi_err      = multi_q;
    assign bus.timeout        = to_q;
    assign bus.ballots_issued = ballots;
endmodule

// File: tb/tb_ballot_capture.sv
// tb_ballot_capture
// Drives ballot_capture through the directed scenarios and a randomized
// session, comparing every cycle against a behavioural model of the booth.
module tb_ballot_capture;
    localparam int DEBOUNCE = 4;
    localparam int TIMEOUT  = 64;
    localparam int CNT_W    = 8;

    logic clk;
    logic rst;

    ballot_capture_if #(.CNT_W(CNT_W)) bus ();

    ballot_capture #(
        .DEBOUNCE(DEBOUNCE),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    int en_seen    = 0;
    int multi_seen = 0;
    int to_seen    = 0;
    logic [2:0] last_vs = 3'b000;

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge; holds the inputs for n cycles.
    task automatic applyStimulus(input logic [2:0] b, input logic bi, input int n);
        bus.btn          = b;
        bus.ballot_issue = bi;
        repeat (n) @(negedge clk);
    endtask

    task automatic resetDut();
        rst              = 1'b1;
        bus.btn          = 3'b000;
        bus.ballot_issue = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Behavioural model of the booth. It tracks what the voter has done in
    // booth terms (synchronised samples, how long each button level has been
    // steady, whether a ballot is open / just voted / waiting for release).
    logic [2:0]       m_h0, m_h1;
    logic             m_b0, m_b1, m_bprev;
    logic [2:0]       m_deb, m_debprev, m_syn, m_deb_old;
    logic             m_bsyn, m_press, m_rise;
    int               m_run [3];
    bit               m_armed, m_voted, m_locked;
    int               m_age;
    logic [2:0]       m_vs;
    logic             m_en, m_multi, m_to;
    logic [CNT_W-1:0] m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h0 = 0; m_h1 = 0; m_b0 = 0; m_b1 = 0; m_bprev = 0;
            m_deb = 0; m_debprev = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_armed = 0; m_voted = 0; m_locked = 0; m_age = 0;
            m_vs = 0; m_en = 0; m_multi = 0; m_to = 0; m_count = 0;
        end else begin
            m_syn     = m_h1;
            m_bsyn    = m_b1;
            m_deb_old = m_deb;
            m_press   = (m_deb != 0) && (m_debprev == 0);
            m_rise    = m_bsyn && !m_bprev;
            m_debprev = m_deb;
            for (int i = 0; i < 3; i++) begin
                if (m_syn[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEBOUNCE) begin
                        m_deb[i] = m_syn[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_h1 = m_h0; m_h0 = bus.btn;
            m_bprev = m_bsyn; m_b1 = m_b0; m_b0 = bus.ballot_issue;

            m_en = 0; m_vs = 0; m_multi = 0; m_to = 0;
            if (m_voted) begin
                m_voted  = 0;
                m_locked = 1;
            end else if (m_locked) begin
                if (m_deb_old == 0 && !m_bsyn) m_locked = 0;
            end else if (m_armed) begin
                m_age++;
                if (m_press && $countones(m_deb_old) == 1) begin
                    m_armed = 0;
                    m_voted = 1;
                    m_en    = 1;
                    m_vs    = m_deb_old;
                end else begin
                    if (m_press) m_multi = 1;
                    if (m_age == TIMEOUT) begin
                        m_armed = 0;
                        m_to    = 1;
                    end
                end
            end else if (m_rise) begin
                m_armed = 1;
                m_age   = 0;
                m_count = m_count + 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, plus event tallies
    // used by the directed scenarios.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("en", bus.en, m_en);
            checkOutput("vswitch", bus.vswitch, m_vs);
            checkOutput("ready", bus.ready, m_armed);
            checkOutput("multi_err", bus.multi_err, m_multi);
            checkOutput("timeout", bus.timeout, m_to);
            checkOutput("ballots_issued", bus.ballots_issued, m_count);
            checkOutput("onehot_inv",
                        $onehot0(bus.vswitch) && (bus.en == (bus.vswitch != 0)), 1);
            if (bus.en) begin
                en_seen++;
                last_vs = bus.vswitch;
            end
            if (bus.multi_err) multi_seen++;
            if (bus.timeout) to_seen++;
        end
    end

    initial begin
        int lat;
        rst              = 1'b1;
        bus.btn          = 3'b000;
        bus.ballot_issue = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_ready", bus.ready, 0);
        checkOutput("reset_count", bus.ballots_issued, 0);
        checkOutput("reset_en", bus.en, 0);

        // 1: presses without a ballot are ignored
        $display("[TB] scenario 1: idle press");
        en_seen = 0;
        applyStimulus(3'b001, 0, 20);
        checkOutput("idle_no_en", en_seen, 0);
        checkOutput("idle_ready", bus.ready, 0);
        checkOutput("idle_count", bus.ballots_issued, 0);
        applyStimulus(3'b000, 0, 10);

        // 2: single valid vote with latency measurement
        $display("[TB] scenario 2: single vote");
        en_seen = 0;
        applyStimulus(3'b000, 1, 2);
        applyStimulus(3'b000, 0, 3);
        checkOutput("armed_ready", bus.ready, 1);
        checkOutput("armed_count", bus.ballots_issued, 1);
        bus.btn = 3'b010;
        lat = 0;
        while (!bus.en && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("vote_latency", lat, 2 + DEBOUNCE + 1);
        applyStimulus(3'b010, 0, 13);
        checkOutput("vote_count", en_seen, 1);
        checkOutput("vote_vs", last_vs, 3'b010);
        checkOutput("vote_ready_off", bus.ready, 0);
        applyStimulus(3'b000, 0, 10);

        // 3: bouncing button, then multi-press, then valid vote
        $display("[TB] scenario 3: bounce and multi-press");
        en_seen = 0;
        multi_seen = 0;
        applyStimulus(3'b000, 1, 2);
        applyStimulus(3'b000, 0, 3);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b010, 0, 2);
            applyStimulus(3'b000, 0, 2);
        end
        checkOutput("bounce_no_en", en_seen, 0);
        applyStimulus(3'b011, 0, 10);
        checkOutput("multi_pulses", multi_seen, 1);
        checkOutput("multi_still_armed", bus.ready, 1);
        applyStimulus(3'b000, 0, 10);
        applyStimulus(3'b100, 0, 12);
        checkOutput("retry_en", en_seen, 1);
        checkOutput("retry_vs", last_vs, 3'b100);
        applyStimulus(3'b000, 0, 10);

        // 4: unused ballot expires
        $display("[TB] scenario 4: timeout");
        en_seen = 0;
        to_seen = 0;
        applyStimulus(3'b000, 1, 2);
        applyStimulus(3'b000, 0, 80);
        checkOutput("timeout_pulses", to_seen, 1);
        checkOutput("timeout_ready", bus.ready, 0);
        applyStimulus(3'b001, 0, 20);
        checkOutput("timeout_no_en", en_seen, 0);
        applyStimulus(3'b000, 0, 10);

        // 5: held and repeated presses are locked out
        $display("[TB] scenario 5: lockout");
        resetDut();
        en_seen = 0;
        applyStimulus(3'b000, 1, 2);
        applyStimulus(3'b000, 0, 3);
        applyStimulus(3'b001, 0, 100);
        checkOutput("lock_held", en_seen, 1);
        applyStimulus(3'b000, 0, 10);
        applyStimulus(3'b001, 0, 20);
        checkOutput("lock_repeat", en_seen, 1);
        applyStimulus(3'b000, 0, 10);
        applyStimulus(3'b000, 1, 2);
        applyStimulus(3'b000, 0, 3);
        applyStimulus(3'b001, 0, 20);
        checkOutput("lock_second", en_seen, 2);
        checkOutput("lock_count", bus.ballots_issued, 2);
        applyStimulus(3'b000, 0, 10);

        // Randomized session against the model
        $display("[TB] randomized session");
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1: applyStimulus(bus.btn, 1, $urandom_range(1, 4));
                2:    applyStimulus(3'b000, 0, 70);
                3: begin
                    for (int k = 0; k < 3; k++)
                        applyStimulus(3'($urandom_range(0, 7)), 0, $urandom_range(1, 3));
                end
                default: applyStimulus(3'($urandom_range(0, 7)), 0, $urandom_range(1, 25));
            endcase
        end
        applyStimulus(3'b000, 0, 10);

        // 6: asynchronous reset in the middle of a ballot
        $display("[TB] scenario 6: async reset mid-ballot");
        resetDut();
        applyStimulus(3'b000, 1, 2);
        applyStimulus(3'b000, 0, 3);
        checkOutput("pre_reset_ready", bus.ready, 1);
        bus.btn = 3'b001;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_ready", bus.ready, 0);
        checkOutput("async_en", bus.en, 0);
        checkOutput("async_vs", bus.vswitch, 0);
        checkOutput("async_count", bus.ballots_issued, 0);
        @(negedge clk);
        rst = 1'b0;
        en_seen = 0;
        applyStimulus(3'b001, 0, 30);
        checkOutput("after_reset_no_en", en_seen, 0);
        applyStimulus(3'b000, 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
